// File: rtl/tone_sequencer_mixer_pkg.sv
// Shared constants, song-table entry type and the song table itself.
package tone_sequencer_mixer_pkg;

    localparam longint      AMP_DEFAULT       = 100000000;
    localparam int unsigned UNIT_CLKS_DEFAULT = 6250000;
    localparam int unsigned SONG_LEN_DEFAULT  = 51;

    // Half-period constants in 50 MHz clocks (primes mark octaves).
    localparam logic [19:0] HP_A1   = 20'd56818;   // A'
    localparam logic [19:0] HP_B1   = 20'd50000;   // B'
    localparam logic [19:0] HP_C2   = 20'd48076;   // C''
    localparam logic [19:0] HP_D2   = 20'd43103;   // D''
    localparam logic [19:0] HP_E2   = 20'd37878;   // E''
    localparam logic [19:0] HP_F2   = 20'd35714;   // F''
    localparam logic [19:0] HP_G2   = 20'd32051;   // G''
    localparam logic [19:0] HP_A2   = 20'd28409;   // A''
    localparam logic [19:0] HP_E1   = 20'd75757;   // E'
    localparam logic [19:0] HP_C1   = 20'd96153;   // C'
    localparam logic [19:0] HP_D1   = 20'd86206;   // D'
    localparam logic [19:0] HP_B0   = 20'd100000;  // B
    localparam logic [19:0] HP_A0   = 20'd113636;  // A
    localparam logic [19:0] HP_GS0  = 20'd120772;  // G#
    localparam logic [19:0] HP_GS1  = 20'd60240;   // G#'
    localparam logic [19:0] HP_REST = 20'd0;

    typedef struct packed {
        logic [19:0] half;
        logic [3:0]  units;
    } song_entry_t;

    function automatic song_entry_t mk(input logic [19:0] h, input logic [3:0] u);
        song_entry_t e;
        e.half  = h;
        e.units = u;
        return e;
    endfunction

    function automatic song_entry_t song_entry(input logic [5:0] idx);
        case (idx)
            6'd0:  return mk(HP_E2, 4'd2);
            6'd1:  return mk(HP_B1, 4'd1);
            6'd2:  return mk(HP_C2, 4'd1);
            6'd3:  return mk(HP_D2, 4'd2);
            6'd4:  return mk(HP_C2, 4'd1);
            6'd5:  return mk(HP_B1, 4'd1);
            6'd6:  return mk(HP_A1, 4'd2);
            6'd7:  return mk(HP_A1, 4'd3);
            6'd8:  return mk(HP_C2, 4'd1);
            6'd9:  return mk(HP_E2, 4'd2);
            6'd10: return mk(HP_D2, 4'd1);
            6'd11: return mk(HP_C2, 4'd1);
            6'd12: return mk(HP_B1, 4'd3);
            6'd13: return mk(HP_C2, 4'd1);
            6'd14: return mk(HP_D2, 4'd2);
            6'd15: return mk(HP_E2, 4'd2);
            6'd16: return mk(HP_REST, 4'd2);
            6'd17: return mk(HP_C2, 4'd2);
            6'd18: return mk(HP_A1, 4'd2);
            6'd19: return mk(HP_A1, 4'd2);
            6'd20: return mk(HP_D2, 4'd3);
            6'd21: return mk(HP_F2, 4'd1);
            6'd22: return mk(HP_A2, 4'd2);
            6'd23: return mk(HP_G2, 4'd1);
            6'd24: return mk(HP_F2, 4'd1);
            6'd25: return mk(HP_E2, 4'd3);
            6'd26: return mk(HP_C2, 4'd1);
            6'd27: return mk(HP_E2, 4'd2);
            6'd28: return mk(HP_D2, 4'd1);
            6'd29: return mk(HP_C2, 4'd1);
            6'd30: return mk(HP_B1, 4'd2);
            6'd31: return mk(HP_B1, 4'd1);
            6'd32: return mk(HP_C2, 4'd1);
            6'd33: return mk(HP_REST, 4'd2);
            6'd34: return mk(HP_E1, 4'd4);
            6'd35: return mk(HP_C1, 4'd4);
            6'd36: return mk(HP_D1, 4'd4);
            6'd37: return mk(HP_B0, 4'd4);
            6'd38: return mk(HP_C1, 4'd4);
            6'd39: return mk(HP_A0, 4'd4);
            6'd40: return mk(HP_GS0, 4'd4);
            6'd41: return mk(HP_B0, 4'd4);
            6'd42: return mk(HP_E1, 4'd4);
            6'd43: return mk(HP_C1, 4'd4);
            6'd44: return mk(HP_D1, 4'd4);
            6'd45: return mk(HP_B0, 4'd4);
            6'd46: return mk(HP_C1, 4'd2);
            6'd47: return mk(HP_E1, 4'd2);
            6'd48: return mk(HP_A1, 4'd4);
            6'd49: return mk(HP_GS1, 4'd4);
            6'd50: return mk(HP_A1, 4'd4);
            default: return mk(HP_REST, 4'd1);
        endcase
    endfunction

endpackage

// File: rtl/tone_sequencer_mixer_square_voice.sv
// One square-wave voice: phase counter, polarity, duration counter, active flag.
module square_voice #(
    parameter int unsigned       HALF_W     = 20,
    parameter int unsigned       DUR_W      = 28,
    parameter int unsigned       SAMPLE_W   = 32,
    parameter longint            AMP        = 100000000,
    parameter bit                RST_ACTIVE = 1'b0,
    parameter logic [HALF_W-1:0] RST_HALF   = '0,
    parameter logic [DUR_W-1:0]  RST_DUR    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                load,
    input  logic                stop,
    input  logic [HALF_W-1:0]   half_in,
    input  logic [DUR_W-1:0]    dur_in,
    output logic                active,
    output logic                done,
    output logic [SAMPLE_W-1:0] value
);

    localparam logic [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMP);
    localparam logic [SAMPLE_W-1:0] AMP_NEG = ~AMP_POS + SAMPLE_W'(1);

    logic [HALF_W-1:0] half;
    logic [HALF_W-1:0] phase;
    logic [DUR_W-1:0]  dur;
    logic [DUR_W-1:0]  dcnt;
    logic              pol;
    logic              phase_wrap;
    logic              dur_end;

    // Wrap on >= so a half period that shrank mid-tone still wraps.
    assign phase_wrap = (phase >= half - HALF_W'(1));
    assign dur_end    = (dcnt >= dur - DUR_W'(1));
    assign done       = active && run && dur_end;

    // Voice state: load restarts the tone, stop silences it, run advances counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            half   <= RST_HALF;
            dur    <= RST_DUR;
            phase  <= '0;
            dcnt   <= '0;
            pol    <= 1'b1;
            active <= RST_ACTIVE;
        end else if (load) begin
            half   <= half_in;
            dur    <= dur_in;
            phase  <= '0;
            dcnt   <= '0;
            pol    <= 1'b1;
            active <= 1'b1;
        end else if (stop) begin
            phase  <= '0;
            dcnt   <= '0;
            pol    <= 1'b1;
            active <= 1'b0;
        end else if (active && run) begin
            if (half != '0) begin
                if (phase_wrap) begin
                    phase <= '0;
                    pol   <= ~pol;
                end else begin
                    phase <= phase + HALF_W'(1);
                end
            end
            if (dur_end) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DUR_W'(1);
            end
        end
    end

    // Output level: +/-AMP while sounding, 0 when inactive or half period is 0.
    always_comb begin
        value = '0;
        if (active && (half != '0)) begin
            value = pol ? AMP_POS : AMP_NEG;
        end
    end

endmodule

// File: rtl/tone_sequencer_mixer.sv
// Song sequencer plus N_SFX triggerable effect voices, mixed with saturation.
module tone_sequencer_mixer
    import tone_sequencer_mixer_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 32,
    parameter longint      AMP       = AMP_DEFAULT,
    parameter int unsigned N_SFX     = 2,
    parameter int unsigned HALF_W    = 20,
    parameter int unsigned DUR_W     = 28,
    parameter int unsigned UNIT_CLKS = UNIT_CLKS_DEFAULT,
    parameter int unsigned SONG_LEN  = SONG_LEN_DEFAULT
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      music_en,
    input  logic                      music_restart,
    input  logic [1:0]                tempo_shift,
    input  logic [N_SFX-1:0]          sfx_play,
    input  logic [N_SFX*HALF_W-1:0]   sfx_half_period,
    input  logic [N_SFX*DUR_W-1:0]    sfx_dur,
    output logic [N_SFX-1:0]          sfx_busy,
    output logic [5:0]                note_index,
    output logic [SAMPLE_W-1:0]       mix_out,
    output logic                      clip
);

    localparam int unsigned ACC_W = SAMPLE_W + 3;

    function automatic logic [DUR_W-1:0] note_dur(input logic [3:0] units, input logic [1:0] shift);
        logic [DUR_W-1:0] clks;
        clks = DUR_W'(units) * DUR_W'(UNIT_CLKS);
        clks = clks >> shift;
        return (clks == '0) ? DUR_W'(1) : clks;
    endfunction

    localparam song_entry_t         ENTRY0    = song_entry(6'd0);
    localparam logic [HALF_W-1:0]   MUS_RST_H = HALF_W'(ENTRY0.half);
    localparam logic [DUR_W-1:0]    MUS_RST_D = note_dur(ENTRY0.units, 2'd0);

    logic [5:0]                next_index;
    song_entry_t               load_entry;
    logic                      music_load;
    logic                      music_done;
    logic                      music_active;
    logic [SAMPLE_W-1:0]       music_raw;
    logic [SAMPLE_W-1:0]       music_val;
    logic [N_SFX*SAMPLE_W-1:0] sfx_vals;
    logic [ACC_W-1:0]          acc;
    logic                      in_range;
    logic [SAMPLE_W-1:0]       sat_val;

    // Next song entry, wrapping after the last table entry.
    always_comb begin
        next_index = note_index + 6'd1;
        if (note_index >= 6'(SONG_LEN - 1)) begin
            next_index = '0;
        end
        load_entry = song_entry(music_restart ? 6'd0 : next_index);
    end

    assign music_load = music_restart | music_done;
    assign music_val  = (music_en && music_active) ? music_raw : '0;

    // Song position: restart returns to entry 0, note end advances.
    always_ff @(posedge CLOCK_50) begin
        if (reset || music_restart) begin
            note_index <= '0;
        end else if (music_done) begin
            note_index <= next_index;
        end
    end

    square_voice #(
        .HALF_W    (HALF_W),
        .DUR_W     (DUR_W),
        .SAMPLE_W  (SAMPLE_W),
        .AMP       (AMP),
        .RST_ACTIVE(1'b1),
        .RST_HALF  (MUS_RST_H),
        .RST_DUR   (MUS_RST_D)
    ) u_music (
        .clk    (CLOCK_50),
        .reset  (reset),
        .run    (music_en),
        .load   (music_load),
        .stop   (1'b0),
        .half_in(HALF_W'(load_entry.half)),
        .dur_in (note_dur(load_entry.units, tempo_shift)),
        .active (music_active),
        .done   (music_done),
        .value  (music_raw)
    );

    for (genvar g = 0; g < N_SFX; g++) begin : g_sfx
        logic [HALF_W-1:0] half_g;
        logic [DUR_W-1:0]  dur_g;
        logic              trig;
        logic              stop;
        logic              done;

        assign half_g = sfx_half_period[g*HALF_W +: HALF_W];
        assign dur_g  = sfx_dur[g*DUR_W +: DUR_W];
        assign trig   = sfx_play[g] && (dur_g != '0);
        // Effect voices expire by feeding their own end-of-duration back as stop.
        assign stop   = (sfx_play[g] && (dur_g == '0)) || done;

        square_voice #(
            .HALF_W  (HALF_W),
            .DUR_W   (DUR_W),
            .SAMPLE_W(SAMPLE_W),
            .AMP     (AMP)
        ) u_voice (
            .clk    (CLOCK_50),
            .reset  (reset),
            .run    (1'b1),
            .load   (trig),
            .stop   (stop),
            .half_in(half_g),
            .dur_in (dur_g),
            .active (sfx_busy[g]),
            .done   (done),
            .value  (sfx_vals[g*SAMPLE_W +: SAMPLE_W])
        );
    end

    // Sign-extended sum of all voices and saturation to the sample range.
    always_comb begin
        acc = {{3{music_val[SAMPLE_W-1]}}, music_val};
        for (int unsigned i = 0; i < N_SFX; i++) begin
            acc = acc + {{3{sfx_vals[i*SAMPLE_W + SAMPLE_W - 1]}}, sfx_vals[i*SAMPLE_W +: SAMPLE_W]};
        end
        in_range = (acc[ACC_W-1:SAMPLE_W-1] == '0) || (acc[ACC_W-1:SAMPLE_W-1] == '1);
        sat_val  = acc[SAMPLE_W-1:0];
        if (!in_range) begin
            sat_val = acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

    // Output sample register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mix_out <= '0;
            clip    <= 1'b0;
        end else begin
            mix_out <= sat_val;
            clip    <= ~in_range;
        end
    end

endmodule

// File: tb/tb_tone_sequencer_mixer.sv
// Bench for tone_sequencer_mixer: table-driven sfx shots plus hand sequences,
// with a per-cycle scoreboard fed by a behavioural model.
module tb_tone_sequencer_mixer;
    import tone_sequencer_mixer_pkg::*;

    localparam int     SW = 32;
    localparam longint A  = 1200000000;
    localparam int     NS = 2;
    localparam int     HW = 20;
    localparam int     DW = 28;
    localparam int     UC = 2;
    localparam int     SL = 51;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             music_en = 1'b0;
    logic             music_restart = 1'b0;
    logic [1:0]       tempo_shift = 2'd0;
    logic [NS-1:0]    sfx_play = '0;
    logic [NS*HW-1:0] sfx_half_period = '0;
    logic [NS*DW-1:0] sfx_dur = '0;
    logic [NS-1:0]    sfx_busy;
    logic [5:0]       note_index;
    logic [SW-1:0]    mix_out;
    logic             clip;

    always #5 clk = ~clk;

    tone_sequencer_mixer #(
        .SAMPLE_W (SW),
        .AMP      (A),
        .N_SFX    (NS),
        .HALF_W   (HW),
        .DUR_W    (DW),
        .UNIT_CLKS(UC),
        .SONG_LEN (SL)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .music_en       (music_en),
        .music_restart  (music_restart),
        .tempo_shift    (tempo_shift),
        .sfx_play       (sfx_play),
        .sfx_half_period(sfx_half_period),
        .sfx_dur        (sfx_dur),
        .sfx_busy       (sfx_busy),
        .note_index     (note_index),
        .mix_out        (mix_out),
        .clip           (clip)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] mix;
        logic        clip;
        logic [1:0]  busy;
        logic [5:0]  idx;
    } exp_t;
    exp_t sbq[$];

    // Behavioural model state.
    int sv_busy[NS];
    int sv_k[NS];
    int sv_half[NS];
    int sv_dur[NS];
    int m_idx = 0;
    int m_k = 0;
    int m_dur = 4;

    // Last observed DUT outputs.
    logic [31:0] o_mix;
    logic        o_clip;
    logic [1:0]  o_busy;
    logic [5:0]  o_idx;

    typedef struct {
        logic [1:0] play;
        int h0, d0, h1, d1;
        int ncyc;
        int exp_b0, exp_b1, exp_clips;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sq(input int half, input int k);
        return (((k / half) % 2) == 0) ? A : -A;
    endfunction

    function automatic int calc_dur(input int idx, input int shift);
        song_entry_t e;
        int d;
        e = song_entry(6'(idx));
        d = (int'(e.units) * UC) >> shift;
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int music_half(input int idx);
        song_entry_t e;
        e = song_entry(6'(idx));
        return int'(e.half);
    endfunction

    task automatic set_sfx(input int i, input int h, input int d);
        sfx_half_period[i*HW +: HW] = HW'(h);
        sfx_dur[i*DW +: DW] = DW'(d);
    endtask

    // Predict one edge from the currently driven inputs, then sample and compare.
    task automatic cycle();
        exp_t   e;
        exp_t   got;
        longint s;
        int     h;
        int     d;
        s = 0;
        if (music_en && music_half(m_idx) != 0) s += sq(music_half(m_idx), m_k);
        for (int i = 0; i < NS; i++)
            if (sv_busy[i] != 0 && sv_half[i] != 0) s += sq(sv_half[i], sv_k[i]);
        if (reset) begin
            e.mix = '0;
            e.clip = 1'b0;
        end else if (s > MAXP) begin
            e.mix = 32'h7FFF_FFFF;
            e.clip = 1'b1;
        end else if (s < MINN) begin
            e.mix = 32'h8000_0000;
            e.clip = 1'b1;
        end else begin
            e.mix = 32'(s);
            e.clip = 1'b0;
        end
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                sv_busy[i] = 0;
                sv_k[i] = 0;
            end
            m_idx = 0;
            m_k = 0;
            m_dur = calc_dur(0, 0);
        end else begin
            for (int i = 0; i < NS; i++) begin
                h = int'(sfx_half_period[i*HW +: HW]);
                d = int'(sfx_dur[i*DW +: DW]);
                if (sfx_play[i] && d != 0) begin
                    sv_busy[i] = 1;
                    sv_k[i] = 0;
                    sv_half[i] = h;
                    sv_dur[i] = d;
                end else if (sfx_play[i]) begin
                    sv_busy[i] = 0;
                end else if (sv_busy[i] != 0) begin
                    sv_k[i]++;
                    if (sv_k[i] >= sv_dur[i]) sv_busy[i] = 0;
                end
            end
            if (music_restart) begin
                m_idx = 0;
                m_k = 0;
                m_dur = calc_dur(0, int'(tempo_shift));
            end else if (music_en) begin
                if (m_k >= m_dur - 1) begin
                    m_idx = (m_idx + 1) % SL;
                    m_k = 0;
                    m_dur = calc_dur(m_idx, int'(tempo_shift));
                end else begin
                    m_k++;
                end
            end
        end
        e.busy = {sv_busy[1] != 0, sv_busy[0] != 0};
        e.idx = 6'(m_idx);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o_mix = mix_out;
        o_clip = clip;
        o_busy = sfx_busy;
        o_idx = note_index;
        got = sbq.pop_front();
        check("mix_out", {32'b0, o_mix}, {32'b0, got.mix});
        check("clip", {63'b0, o_clip}, {63'b0, got.clip});
        check("sfx_busy", {62'b0, o_busy}, {62'b0, got.busy});
        check("note_index", {58'b0, o_idx}, {58'b0, got.idx});
    endtask

    initial begin
        int b0, b1, nclip, c7, c9;

        //          play   h0 d0  h1 d1  ncyc b0  b1  clips
        tbl[0] = '{2'b01, 4, 20, 0, 0,  23, 20, 0,  0};
        tbl[1] = '{2'b11, 8, 24, 8, 24, 27, 24, 24, 24};
        tbl[2] = '{2'b10, 0, 0,  0, 10, 13, 0,  10, 0};
        tbl[3] = '{2'b01, 5, 0,  0, 0,  4,  0,  0,  0};
        tbl[4] = '{2'b11, 3, 7,  5, 12, 15, 7,  12, 4};
        tbl[5] = '{2'b01, 1, 6,  0, 0,  9,  6,  0,  0};

        for (int i = 0; i < NS; i++) begin
            sv_busy[i] = 0;
            sv_k[i] = 0;
            sv_half[i] = 0;
            sv_dur[i] = 0;
        end

        // Power-on reset, three cycles.
        repeat (3) cycle();
        reset = 1'b0;
        check("reset_mix", {32'b0, o_mix}, 64'd0);
        check("reset_idx", {58'b0, o_idx}, 64'd0);

        // Table of effect shots with music paused.
        for (int v = 0; v < 6; v++) begin
            set_sfx(0, tbl[v].h0, tbl[v].d0);
            set_sfx(1, tbl[v].h1, tbl[v].d1);
            sfx_play = tbl[v].play;
            b0 = 0; b1 = 0; nclip = 0;
            for (int c = 0; c < tbl[v].ncyc; c++) begin
                cycle();
                sfx_play = '0;
                b0 += int'(o_busy[0]);
                b1 += int'(o_busy[1]);
                nclip += int'(o_clip);
            end
            check($sformatf("vec%0d_busy0_len", v), 64'(b0), 64'(tbl[v].exp_b0));
            check($sformatf("vec%0d_busy1_len", v), 64'(b1), 64'(tbl[v].exp_b1));
            check($sformatf("vec%0d_clips", v), 64'(nclip), 64'(tbl[v].exp_clips));
        end

        // Retrigger at cycle 10 of a 20-cycle shot with a 5-cycle shot.
        set_sfx(0, 4, 20);
        sfx_play = 2'b01;
        cycle();
        sfx_play = '0;
        repeat (9) cycle();
        set_sfx(0, 6, 5);
        sfx_play = 2'b01;
        b0 = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            sfx_play = '0;
            b0 += int'(o_busy[0]);
        end
        check("retrigger_busy_len", 64'(b0), 64'd5);

        // Trigger with dur=0 while busy silences the voice.
        set_sfx(0, 4, 20);
        sfx_play = 2'b01;
        cycle();
        sfx_play = '0;
        repeat (4) cycle();
        set_sfx(0, 4, 0);
        sfx_play = 2'b01;
        cycle();
        sfx_play = '0;
        check("kill_busy", {63'b0, o_busy[0]}, 64'd0);
        repeat (3) cycle();

        // Full song at nominal tempo, through the wrap to entry 0.
        music_restart = 1'b1;
        music_en = 1'b1;
        cycle();
        music_restart = 1'b0;
        for (int s = 1; s <= 240; s++) begin
            cycle();
            if (s == 3) check("song_entry0_last", {58'b0, o_idx}, 64'd0);
            if (s == 4) check("song_entry1_first", {58'b0, o_idx}, 64'd1);
            if (s == 239) check("song_last_entry", {58'b0, o_idx}, 64'd50);
            if (s == 240) check("song_wrap", {58'b0, o_idx}, 64'd0);
        end

        // Pause mid-note 7, resume with tempo_shift=1.
        music_restart = 1'b1;
        cycle();
        music_restart = 1'b0;
        for (int c = 0; c < 300 && o_idx != 6'd7; c++) cycle();
        check("reach_note7", {58'b0, o_idx}, 64'd7);
        cycle();
        music_en = 1'b0;
        repeat (10) cycle();
        check("pause_idx", {58'b0, o_idx}, 64'd7);
        check("pause_mix", {32'b0, o_mix}, 64'd0);
        music_en = 1'b1;
        tempo_shift = 2'd1;
        c7 = 0; c9 = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            c7 += int'(o_idx == 6'd7);
            c9 += int'(o_idx == 6'd9);
        end
        check("resume_note7_rest", 64'(c7), 64'd4);
        check("tempo_note9_len", 64'(c9), 64'd2);

        // Restart while paused: entry 0, music silent.
        music_restart = 1'b1;
        music_en = 1'b0;
        cycle();
        music_restart = 1'b0;
        repeat (3) cycle();
        check("restart_paused_idx", {58'b0, o_idx}, 64'd0);
        check("restart_paused_mix", {32'b0, o_mix}, 64'd0);

        // Reset mid-song with both effect voices busy.
        tempo_shift = 2'd0;
        music_en = 1'b1;
        music_restart = 1'b1;
        cycle();
        music_restart = 1'b0;
        repeat (20) cycle();
        set_sfx(0, 8, 100);
        set_sfx(1, 8, 100);
        sfx_play = 2'b11;
        cycle();
        sfx_play = '0;
        repeat (5) cycle();
        check("pre_reset_busy", {62'b0, o_busy}, 64'd3);
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        music_en = 1'b0;
        cycle();
        check("post_reset_mix", {32'b0, o_mix}, 64'd0);
        check("post_reset_clip", {63'b0, o_clip}, 64'd0);
        check("post_reset_busy", {62'b0, o_busy}, 64'd0);
        check("post_reset_idx", {58'b0, o_idx}, 64'd0);
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
